// File: rtl/colour_pkg.sv
// Shared ASCII constants, state type and helpers for the colour word generator/detector.
// The SSP state is only reachable when COLOUR_TRAILING_SPACE_EN is defined.
package colour_pkg;

    localparam logic [6:0] ASCII_C     = 7'h43;
    localparam logic [6:0] ASCII_O     = 7'h4F;
    localparam logic [6:0] ASCII_L     = 7'h4C;
    localparam logic [6:0] ASCII_U     = 7'h55;
    localparam logic [6:0] ASCII_R     = 7'h52;
    localparam logic [6:0] ASCII_SPACE = 7'h20;

    typedef enum logic [3:0] {
        IDLE,
        SC,
        SO1,
        SL,
        SO2,
        SU,
        SR,
        SSP,
        GAP
    } colour_state_e;

    function automatic logic [6:0] state_letter(input colour_state_e s);
        case (s)
            SC:      return ASCII_C;
            SO1:     return ASCII_O;
            SL:      return ASCII_L;
            SO2:     return ASCII_O;
            SU:      return ASCII_U;
            SR:      return ASCII_R;
            SSP:     return ASCII_SPACE;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic state_emits(input colour_state_e s);
        return (s == SC) || (s == SO1) || (s == SL) || (s == SO2) ||
               (s == SU) || (s == SR) || (s == SSP);
    endfunction

endpackage

// File: rtl/colour_gap_timer.sv
// Down-counter timing the idle gap between words; expire_o is high in the last gap cycle.
module colour_gap_timer #(
    parameter int GAP_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expire_o
);

    localparam int W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(GAP_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/colour_word_gen.sv
// Emits "COLOR"/"COLOUR" bursts over a valid/ready handshake with an idle gap between words.
// Define COLOUR_TRAILING_SPACE_EN to append an ASCII space to every word.
module colour_word_gen
    import colour_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             uk,
    input  logic [CNT_W-1:0] words,
    input  logic             ready,
    output logic [6:0]       letter,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    colour_state_e    state_q, state_d;
    logic [6:0]       letter_q, letter_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             uk_q, uk_d;
    logic             hs;
    logic             word_end;
    logic             gap_load;
    logic             gap_expire;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        uk_d     = uk_q;
        done_d   = 1'b0;
        gap_load = 1'b0;
        word_end = 1'b0;
        hs       = valid_q && ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    uk_d    = uk;
                    rem_d   = (words == '0) ? CNT_W'(1) : words;
                    state_d = SC;
                end
            end
            SC:  if (hs) state_d = SO1;
            SO1: if (hs) state_d = SL;
            SL:  if (hs) state_d = SO2;
            SO2: if (hs) state_d = uk_q ? SU : SR;
            SU:  if (hs) state_d = SR;
            SR: begin
                if (hs) begin
`ifdef COLOUR_TRAILING_SPACE_EN
                    state_d = SSP;
`else
                    word_end = 1'b1;
`endif
                end
            end
`ifdef COLOUR_TRAILING_SPACE_EN
            SSP: if (hs) word_end = 1'b1;
`endif
            GAP: if (gap_expire) state_d = SC;
            default: state_d = IDLE;
        endcase

        // Repeat/finish decision is shared by whichever state closes the word
        if (word_end) begin
            if (rem_q > CNT_W'(1)) begin
                rem_d    = rem_q - CNT_W'(1);
                state_d  = (GAP_CYCLES > 0) ? GAP : SC;
                gap_load = (GAP_CYCLES > 0);
            end else begin
                rem_d   = '0;
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        letter_d = state_letter(state_d);
        valid_d  = state_emits(state_d);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            letter_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            uk_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            uk_q     <= uk_d;
        end
    end

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            colour_gap_timer #(
                .GAP_CYCLES(GAP_CYCLES)
            ) u_gap_timer (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (gap_load),
                .expire_o(gap_expire)
            );
        end else begin : g_nogap
            assign gap_expire = 1'b1;
        end
    endgenerate

    assign letter = letter_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_colour_word_gen.sv
// Directed bench for colour_word_gen (CNT_W=4, GAP_CYCLES=2).
module tb_colour_word_gen;

    localparam int GAP = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       uk;
    logic [3:0] words;
    logic       ready;
    logic [6:0] letter;
    logic       valid;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;

    logic [6:0] acc[$];
    logic [6:0] exp_q[$];
    logic [6:0] h[0:5];
    int         done_cnt;
    int         hits;

    colour_word_gen #(
        .CNT_W     (4),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .uk    (uk),
        .words (words),
        .ready (ready),
        .letter(letter),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted-letter monitor with a reference word detector fed on valid&&ready
    always @(posedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && valid && ready) begin
            acc.push_back(letter);
            for (int i = 0; i < 5; i++) h[i] = h[i+1];
            h[5] = letter;
            if (h[1] == 7'h43 && h[2] == 7'h4F && h[3] == 7'h4C && h[4] == 7'h4F && h[5] == 7'h52)
                hits++;
            if (h[0] == 7'h43 && h[1] == 7'h4F && h[2] == 7'h4C && h[3] == 7'h4F && h[4] == 7'h55 && h[5] == 7'h52)
                hits++;
        end
    end

    task automatic clear_mon();
        acc.delete();
        exp_q.delete();
        done_cnt = 0;
        hits     = 0;
        for (int i = 0; i < 6; i++) h[i] = 7'h00;
    endtask

    task automatic add_word(input logic u);
        exp_q.push_back(7'h43);
        exp_q.push_back(7'h4F);
        exp_q.push_back(7'h4C);
        exp_q.push_back(7'h4F);
        if (u) exp_q.push_back(7'h55);
        exp_q.push_back(7'h52);
`ifdef COLOUR_TRAILING_SPACE_EN
        exp_q.push_back(7'h20);
`endif
    endtask

    // Called at a negedge; returns at the negedge after the start edge, with uk/words scrambled
    task automatic pulse_start(input logic u, input logic [3:0] w);
        start = 1'b1;
        uk    = u;
        words = w;
        @(negedge clk);
        start = 1'b0;
        uk    = ~u;
        words = 4'd9;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        uk    = 1'b0;
        words = 4'd0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++;
        if (letter !== 7'h00) begin n_fail++; $display("FAIL reset_letter: got %h want 00", letter); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_us();
        clear_mon();
        add_word(1'b0);
        ready = 1'b1;
        pulse_start(1'b0, 4'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (valid !== 1'b1 || letter !== exp_q[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_letter[%0d]: got v=%b l=%h b=%b want v=1 l=%h b=1", i, valid, letter, busy, exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got d=%b b=%b v=%b want d=1 b=0 v=0", done, busy, valid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_uk_backpressure();
        logic [6:0] prev;
        logic       prev_hold;
        bit         finished;
        clear_mon();
        add_word(1'b1);
        ready = 1'b0;
        pulse_start(1'b1, 4'd1);
        prev_hold = 1'b0;
        prev      = 7'h00;
        finished  = 1'b0;
        for (int c = 0; c < 60 && !finished; c++) begin
            if (prev_hold) begin
                n_checks++;
                if (valid !== 1'b1 || letter !== prev) begin
                    n_fail++;
                    $display("FAIL bp_hold: got v=%b l=%h want v=1 l=%h", valid, letter, prev);
                end
            end
            ready     = ~ready;
            prev_hold = valid && !ready;
            prev      = letter;
            @(negedge clk);
            if (done === 1'b1) finished = 1'b1;
        end
        ready = 1'b1;
        n_checks++;
        if (!finished) begin n_fail++; $display("FAIL bp_timeout: got no done want done"); end
        @(negedge clk);
        n_checks++;
        if (acc.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d letters want %0d", acc.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (acc[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_letter[%0d]: got %h want %h", i, acc[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_repeat_gap();
        int  busy_cyc, valid_cyc, gap_cyc, gap_runs, c;
        logic prev_valid;
        clear_mon();
        add_word(1'b0);
        add_word(1'b0);
        add_word(1'b0);
        ready = 1'b1;
        pulse_start(1'b0, 4'd3);
        busy_cyc = 0; valid_cyc = 0; gap_cyc = 0; gap_runs = 0; c = 0;
        prev_valid = 1'b1;
        while (done !== 1'b1 && c < 100) begin
            if (busy === 1'b1) busy_cyc++;
            if (valid === 1'b1) valid_cyc++;
            if (busy === 1'b1 && valid === 1'b0) begin
                gap_cyc++;
                if (prev_valid) gap_runs++;
            end
            prev_valid = valid;
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL rep_timeout: got no done want done"); end
        n_checks++;
        if (busy_cyc != exp_q.size() + 2 * GAP) begin
            n_fail++;
            $display("FAIL rep_burst_len: got %0d want %0d", busy_cyc, exp_q.size() + 2 * GAP);
        end
        n_checks++;
        if (valid_cyc != exp_q.size()) begin
            n_fail++;
            $display("FAIL rep_valid_cycles: got %0d want %0d", valid_cyc, exp_q.size());
        end
        n_checks++;
        if (gap_cyc != 2 * GAP || gap_runs != 2) begin
            n_fail++;
            $display("FAIL rep_gaps: got %0d cycles in %0d runs want %0d in 2", gap_cyc, gap_runs, 2 * GAP);
        end
        @(negedge clk);
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL rep_done_count: got %0d want 1", done_cnt); end
        n_checks++;
        if (acc != exp_q) begin n_fail++; $display("FAIL rep_stream: got %0d letters want %0d matching", acc.size(), exp_q.size()); end
    endtask

    task automatic test_words_zero();
        bit ok;
        clear_mon();
        add_word(1'b0);
        ready = 1'b1;
        pulse_start(1'b0, 4'd0);
        @(negedge clk);
        start = 1'b1;
        uk    = 1'b1;
        words = 4'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL w0_timeout: got no done want done"); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (acc != exp_q) begin n_fail++; $display("FAIL w0_stream: got %0d letters want %0d matching", acc.size(), exp_q.size()); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL w0_done_count: got %0d want 1", done_cnt); end
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL w0_idle: got v=%b b=%b want v=0 b=0", valid, busy);
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        clear_mon();
        ready = 1'b1;
        pulse_start(1'b0, 4'd2);
        repeat (2) @(negedge clk);
        n_checks++;
        if (letter !== 7'h4C) begin n_fail++; $display("FAIL rst_pre_sl: got %h want 4c", letter); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || letter !== 7'h00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b b=%b l=%h d=%b want v=0 b=0 l=00 d=0", valid, busy, letter, done);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != 0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: got dc=%0d v=%b want dc=0 v=0", done_cnt, valid);
        end
        pulse_start(1'b0, 4'd1);
        n_checks++;
        if (valid !== 1'b1 || letter !== 7'h43) begin
            n_fail++;
            $display("FAIL rst_restart: got v=%b l=%h want v=1 l=43", valid, letter);
        end
        wait_done(40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_restart_timeout: got no done want done"); end
        @(negedge clk);
    endtask

    task automatic test_loopback();
        bit   ok;
        logic u;
        for (int k = 0; k < 2; k++) begin
            u = (k == 1);
            clear_mon();
            ready = 1'b1;
            pulse_start(u, 4'd2);
            wait_done(60, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL loop_timeout uk=%b: got no done want done", u); end
            @(negedge clk);
            n_checks++;
            if (hits != 2) begin n_fail++; $display("FAIL loop_hits uk=%b: got %0d want 2", u, hits); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_mon();
        test_reset();
        test_basic_us();
        test_uk_backpressure();
        test_repeat_gap();
        test_words_zero();
        test_reset_mid_word();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
